// File: rtl/ex_mul_ctrl_pkg.sv
// Shared encodings for the EX-stage multiply controller: ALU op codes,
// multiplier op select and controller state.
package ex_mul_ctrl_pkg;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLL    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_SLT    = 4'd8;
    localparam logic [3:0] ALU_SLTU   = 4'd9;
    localparam logic [3:0] ALU_MUL    = 4'd10;
    localparam logic [3:0] ALU_MULH   = 4'd11;
    localparam logic [3:0] ALU_MULHSU = 4'd12;
    localparam logic [3:0] ALU_MULHU  = 4'd13;

    localparam logic [1:0] MULOP_MUL    = 2'd0;
    localparam logic [1:0] MULOP_MULH   = 2'd1;
    localparam logic [1:0] MULOP_MULHSU = 2'd2;
    localparam logic [1:0] MULOP_MULHU  = 2'd3;

    typedef enum logic [1:0] {
        MULC_IDLE = 2'd0,
        MULC_BUSY = 2'd1,
        MULC_DONE = 2'd2
    } mulc_state_t;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) ||
               (op == ALU_MULHSU) || (op == ALU_MULHU);
    endfunction

    function automatic logic [1:0] mul_op_of(input logic [3:0] op);
        logic [1:0] r;
        case (op)
            ALU_MULH:   r = MULOP_MULH;
            ALU_MULHSU: r = MULOP_MULHSU;
            ALU_MULHU:  r = MULOP_MULHU;
            default:    r = MULOP_MUL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_mul_ctrl.sv
// EX-stage multiply sequencer: issues one start pulse, stalls the front of the
// pipe for the fixed multiplier latency and registers the product for the EX mux.
module ex_mul_ctrl
    import ex_mul_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [3:0]  alu_op,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    input  logic        pipe_hold,
    output logic        mul_start,
    output logic        mul_abort,
    output logic [1:0]  mul_op,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_result_in,
    output logic        mul_stall,
    output logic        mul_res_valid,
    output logic [31:0] mul_res,
    output logic [1:0]  dbg_state
);

    localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 1);

    mulc_state_t state, state_nxt;
    logic [3:0]  cnt;
    logic        is_mul;

    assign is_mul    = is_mul_op(alu_op);
    assign dbg_state = state;

    // flush overrides every state: no start, no stall, abort only an in-flight op
    always_comb begin
        state_nxt     = state;
        mul_start     = 1'b0;
        mul_abort     = 1'b0;
        mul_stall     = 1'b0;
        mul_res_valid = 1'b0;
        if (flush) begin
            state_nxt = MULC_IDLE;
            mul_abort = (state == MULC_BUSY);
        end else begin
            case (state)
                MULC_IDLE: begin
                    if (ex_valid && is_mul) begin
                        mul_start = 1'b1;
                        mul_stall = 1'b1;
                        state_nxt = MULC_BUSY;
                    end
                end
                MULC_BUSY: begin
                    mul_stall = 1'b1;
                    if (cnt == 4'd0) state_nxt = MULC_DONE;
                end
                MULC_DONE: begin
                    mul_res_valid = 1'b1;
                    if (!pipe_hold) state_nxt = MULC_IDLE;
                end
                default: state_nxt = MULC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= MULC_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= 4'd0;
            mul_a   <= 32'd0;
            mul_b   <= 32'd0;
            mul_op  <= MULOP_MUL;
            mul_res <= 32'd0;
        end else if (mul_start) begin
            mul_a  <= rs1_data;
            mul_b  <= rs2_data;
            mul_op <= mul_op_of(alu_op);
            cnt    <= CNT_INIT;
        end else if (state == MULC_BUSY && !flush) begin
            if (cnt == 4'd0) mul_res <= mul_result_in;
            else             cnt     <= cnt - 4'd1;
        end
    end

endmodule
